// File: rtl/riscv_defines.sv
// Shared RISC-V front-end types: instruction word, fetch trap request and the
// IF->ID queue entry that bundles them with the fetch PCs.
package riscv_defines;

  localparam int RV_XLEN = 32;

  typedef logic [31:0] inst_t;

  typedef enum logic [3:0] {
    TRAP_INST_MISALIGNED = 4'd0,
    TRAP_INST_ACCESS     = 4'd1,
    TRAP_ILLEGAL         = 4'd2,
    TRAP_BREAKPOINT      = 4'd3
  } trap_cause_e;

  typedef struct packed {
    logic        valid;
    trap_cause_e cause;
  } trap_req_t;

  // addi x0, x0, 0 -- harmless filler handed to decode when fetch already trapped
  localparam inst_t NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] pcplus4;
    inst_t              inst;
    trap_req_t          trap;
  } fq_entry_t;

endpackage

// File: rtl/id_queue_mem.sv
// Storage array for the IF->ID queue: one synchronous write port and one
// asynchronous read port. Contents are not reset; validity is tracked by the
// pointers in the parent.
module id_queue_mem
  import riscv_defines::*;
#(
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  fq_entry_t        wdata,
  input  logic [IDX_W-1:0] raddr,
  output fq_entry_t        rdata
);

  fq_entry_t mem_q [DEPTH];

  // Write the accepted fetch packet into its slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/id_fetch_queue.sv
// IF->ID decoupling queue. Holds up to DEPTH fetched packets so fetch can keep
// running while decode stalls; the head entry is presented to decode
// first-word-fall-through, and a flush empties the queue in one cycle.
module id_fetch_queue
  import riscv_defines::*;
#(
  parameter  int DEPTH = 4,
  parameter  int XLEN  = RV_XLEN,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [XLEN-1:0]  enq_pc,
  input  logic [XLEN-1:0]  enq_pcplus4,
  input  inst_t            enq_inst,
  input  trap_req_t        enq_trap,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [XLEN-1:0]  deq_pc,
  output logic [XLEN-1:0]  deq_pcplus4,
  output inst_t            deq_inst,
  output trap_req_t        deq_trap,
  output logic [CNT_W-1:0] count
);

  localparam int               IDX_W   = CNT_W - 1;
  localparam logic [CNT_W-1:0] PTR_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      empty, full;
  logic      enq_fire, deq_fire;
  fq_entry_t wr_entry, head;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[IDX_W-1:0] == wr_ptr_q[IDX_W-1:0]) &&
                 (rd_ptr_q[CNT_W-1] != wr_ptr_q[CNT_W-1]);

  // Ready depends only on registered state, never on deq_ready
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign count     = count_q;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  assign wr_entry.pc      = RV_XLEN'(enq_pc);
  assign wr_entry.pcplus4 = RV_XLEN'(enq_pcplus4);
  assign wr_entry.inst    = enq_inst;
  assign wr_entry.trap    = enq_trap;

  id_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (enq_fire),
    .waddr (wr_ptr_q[IDX_W-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr_q[IDX_W-1:0]),
    .rdata (head)
  );

  // Next pointer/occupancy: flush wins, otherwise advance on each handshake
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; asynchronous reset drops every in-flight packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry to decode; bubble of zeros when empty, NOP when fetch trapped
  always_comb begin
    deq_pc      = '0;
    deq_pcplus4 = '0;
    deq_inst    = '0;
    deq_trap    = '0;
    if (!empty) begin
      deq_pc      = XLEN'(head.pc);
      deq_pcplus4 = XLEN'(head.pcplus4);
      deq_inst    = head.trap.valid ? NOP_INST : head.inst;
      deq_trap    = head.trap;
    end
  end

  // Fetch must hold a stalled packet stable until accepted or flushed
  property p_enq_hold;
    @(posedge clk) disable iff (rst)
      (enq_valid && !enq_ready && !flush) |=>
        (flush || (enq_valid && $stable(enq_pc) && $stable(enq_pcplus4) &&
                   $stable(enq_inst) && $stable(enq_trap)));
  endproperty

  a_enq_hold: assert property (p_enq_hold)
    else $error("enq packet dropped or changed while enq_ready was low");

endmodule

// File: tb/tb_id_fetch_queue.sv
// Bench for id_fetch_queue: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_id_fetch_queue;
  import riscv_defines::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk         = 1'b0;
  logic             rst         = 1'b1;
  logic             flush       = 1'b0;
  logic             enq_valid   = 1'b0;
  logic             deq_ready   = 1'b0;
  logic [XLEN-1:0]  enq_pc      = '0;
  logic [XLEN-1:0]  enq_pcplus4 = '0;
  inst_t            enq_inst    = '0;
  trap_req_t        enq_trap    = '0;
  logic             enq_ready;
  logic             deq_valid;
  logic [XLEN-1:0]  deq_pc;
  logic [XLEN-1:0]  deq_pcplus4;
  inst_t            deq_inst;
  trap_req_t        deq_trap;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  fq_entry_t model_q[$];

  id_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_pc      (enq_pc),
    .enq_pcplus4 (enq_pcplus4),
    .enq_inst    (enq_inst),
    .enq_trap    (enq_trap),
    .deq_ready   (deq_ready),
    .deq_valid   (deq_valid),
    .deq_pc      (deq_pc),
    .deq_pcplus4 (deq_pcplus4),
    .deq_inst    (deq_inst),
    .deq_trap    (deq_trap),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    fq_entry_t h;
    logic      ev;
    inst_t     ei;
    ev = (model_q.size() > 0);
    h  = ev ? model_q[0] : '0;
    ei = (ev && h.trap.valid) ? NOP_INST : h.inst;
    chk("m_deq_valid",   64'(deq_valid),   64'(ev));
    chk("m_enq_ready",   64'(enq_ready),   64'(model_q.size() < DEPTH));
    chk("m_count",       64'(count),       64'(model_q.size()));
    chk("m_deq_pc",      64'(deq_pc),      64'(h.pc));
    chk("m_deq_pcplus4", 64'(deq_pcplus4), 64'(h.pcplus4));
    chk("m_deq_inst",    64'(deq_inst),    64'(ei));
    chk("m_deq_trap",    64'(deq_trap),    64'(h.trap));
  endtask

  // Reference model: a plain FIFO of packets updated from the inputs seen at each edge
  always @(posedge clk or posedge rst) begin
    bit can_enq;
    bit can_deq;
    if (rst) begin
      model_q.delete();
    end else begin
      can_enq = enq_valid && (model_q.size() < DEPTH);
      can_deq = deq_ready && (model_q.size() > 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (can_deq) void'(model_q.pop_front());
        if (can_enq) model_q.push_back(fq_entry_t'{pc: enq_pc, pcplus4: enq_pcplus4,
                                                   inst: enq_inst, trap: enq_trap});
      end
      #1;
      if (!rst) compare_model();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_enq(input logic v, input logic [XLEN-1:0] pc, input inst_t inst,
                         input trap_req_t tr);
    enq_valid   = v;
    enq_pc      = pc;
    enq_pcplus4 = pc + 32'd4;
    enq_inst    = inst;
    enq_trap    = tr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] seq [5];
    trap_req_t       no_trap;
    trap_req_t       ill;
    no_trap = '0;
    ill     = '{valid: 1'b1, cause: TRAP_ILLEGAL};
    seq     = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_deq_pc",    64'(deq_pc),    64'd0);
    rst = 1'b0;
    step();

    // 1: single enqueue, visible the cycle after
    set_enq(1'b1, 32'h100, 32'h0050_0093, no_trap);
    #1;
    chk("t1_no_bypass", 64'(deq_valid), 64'd0);
    step();
    enq_valid = 1'b0;
    chk("t1_deq_valid", 64'(deq_valid), 64'd1);
    chk("t1_deq_pc",    64'(deq_pc),    64'h100);
    chk("t1_deq_inst",  64'(deq_inst),  64'h0050_0093);
    chk("t1_count",     64'(count),     64'd1);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("t1_drained", 64'(count), 64'd0);

    // 2: fill to DEPTH, fifth packet held off, then drain in order
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, seq[i], 32'h1000_0000 + seq[i], no_trap);
      step();
    end
    chk("t2_enq_ready", 64'(enq_ready), 64'd0);
    chk("t2_count",     64'(count),     64'd4);
    set_enq(1'b1, seq[4], 32'h1000_0010, no_trap);
    step();
    chk("t2_fifth_blocked", 64'(count),  64'd4);
    chk("t2_head",          64'(deq_pc), 64'h0);
    deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", 64'(deq_pc), 64'(seq[i]));
      step();
      if (i == 1) enq_valid = 1'b0;
    end
    deq_ready = 1'b0;
    chk("t2_empty", 64'(deq_valid), 64'd0);

    // 3: steady simultaneous enq/deq at count=2
    set_enq(1'b1, 32'h200, 32'h2000_0000, no_trap);
    step();
    set_enq(1'b1, 32'h204, 32'h2000_0004, no_trap);
    step();
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_enq(1'b1, 32'h208 + 32'(4 * i), 32'h2000_0008 + 32'(4 * i), no_trap);
      chk("t3_seq",   64'(deq_pc), 64'(32'h200 + 32'(4 * i)));
      chk("t3_count", 64'(count),  64'd2);
      step();
    end
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    chk("t3_count_end", 64'(count),  64'd2);
    chk("t3_head_end",  64'(deq_pc), 64'h228);

    // 4: flush with competing enq and deq
    set_enq(1'b1, 32'h300, 32'h3000_0000, no_trap);
    step();
    chk("t4_count3", 64'(count), 64'd3);
    flush     = 1'b1;
    deq_ready = 1'b1;
    set_enq(1'b1, 32'h400, 32'h4000_0000, no_trap);
    step();
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    chk("t4_count",     64'(count),     64'd0);
    chk("t4_deq_valid", 64'(deq_valid), 64'd0);
    chk("t4_deq_pc",    64'(deq_pc),    64'd0);
    chk("t4_deq_inst",  64'(deq_inst),  64'd0);
    chk("t4_deq_trap",  64'(deq_trap),  64'd0);
    repeat (2) step();
    chk("t4_no_ghost", 64'(deq_valid), 64'd0);

    // 5: fetch-side trap replaces the instruction with a NOP
    set_enq(1'b1, 32'h500, 32'hFFFF_FFFF, ill);
    step();
    enq_valid = 1'b0;
    chk("t5_deq_inst", 64'(deq_inst), 64'h0000_0013);
    chk("t5_deq_trap", 64'(deq_trap), 64'(ill));
    chk("t5_deq_pc",   64'(deq_pc),   64'h500);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;

    // 6: asynchronous reset mid-cycle with three entries
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'h600 + 32'(4 * i), 32'h6000_0000, no_trap);
      step();
    end
    enq_valid = 1'b0;
    chk("t6_count3", 64'(count), 64'd3);
    @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    chk("t6_deq_valid", 64'(deq_valid), 64'd0);
    chk("t6_count",     64'(count),     64'd0);
    chk("t6_enq_ready", 64'(enq_ready), 64'd1);
    #1;
    rst = 1'b0;
    step();
    set_enq(1'b1, 32'h700, 32'h7000_0000, no_trap);
    step();
    enq_valid = 1'b0;
    chk("t6_after_rst", 64'(deq_pc), 64'h700);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
